step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 144 ++++++++++++++
 tb/tb_step_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Scene step sequencer: LOAD/HOLD/ADVANCE per scene with a tick-based HOLD timeout.
// Define SEQ_LOOP_EN to wrap from the last scene back to scene 0 instead of finishing.
module step_sequencer #(
  parameter int TICK_DIV      = 25000000,
  parameter int TIMEOUT_TICKS = 5,
  parameter int NUM_SCENES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       timer_done,
  output logic [3:0] step,
  output logic [3:0] scene,
  output logic       busy,
  output logic       timeout_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 2);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);
  localparam logic [3:0] LAST = 4'(NUM_SCENES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_PAUSED,
    S_ADV,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    scene_q, scene_d;
  logic [3:0]    step_q, step_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          tick_w;
  logic          to_w;
  logic [TW-1:0] tinc_w;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    scene_d = scene_q;
    err_d   = err_q;
    tick_w  = (presc_q == PMAX);
    // Tick count saturates so a pause landing on the timeout edge is not lost
    tinc_w  = (tick_w && (tcnt_q < TMAX)) ? tcnt_q + 1'b1 : tcnt_q;
    to_w    = (tinc_w >= TMAX);
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (start) begin
          state_d = S_LOAD;
          scene_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        presc_d = '0;
        tcnt_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        presc_d = tick_w ? '0 : presc_q + 1'b1;
        tcnt_d  = tinc_w;
        if (timer_done) begin
          state_d = S_ADV;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else if (to_w) begin
          state_d = S_ADV;
          err_d   = 1'b1;
        end
      end
      S_PAUSED: begin
        if (!pause) state_d = S_HOLD;
      end
      S_ADV: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (scene_q < LAST) begin
          scene_d = scene_q + 1'b1;
          state_d = S_LOAD;
        end else begin
`ifdef SEQ_LOOP_EN
          scene_d = '0;
          state_d = S_LOAD;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: begin
        presc_d = '0;
        tcnt_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and then registered
    unique case (state_d)
      S_LOAD:  step_d = 4'b0001;
      S_HOLD:  step_d = 4'b0010;
      S_ADV:   step_d = 4'b0100;
      S_DONE:  step_d = 4'b1000;
      default: step_d = 4'b0000;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      scene_q <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      scene_q <= scene_d;
      step_q  <= step_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign step        = step_q;
  assign scene       = scene_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed and random bench for step_sequencer against a behavioural model.
// The model counts elapsed HOLD clocks directly instead of prescaler/tick pairs.
module tb_step_sequencer;

  localparam int TD    = 4;
  localparam int TO    = 5;
  localparam int NS    = 3;
  localparam int LIMIT = TD * TO;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_PAUSE = 3;
  localparam int P_ADV   = 4;
  localparam int P_DONE  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       timer_done = 1'b0;
  logic [3:0] step;
  logic [3:0] scene;
  logic       busy;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int ph = P_IDLE;
  int m_scene = 0;
  bit m_err = 1'b0;
  int elapsed = 0;

  step_sequencer #(
    .TICK_DIV(TD),
    .TIMEOUT_TICKS(TO),
    .NUM_SCENES(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .timer_done(timer_done),
    .step(step),
    .scene(scene),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_step(input int p);
    case (p)
      P_LOAD:  return 4'b0001;
      P_HOLD:  return 4'b0010;
      P_ADV:   return 4'b0100;
      P_DONE:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    if (!rst) begin
      ph = P_IDLE;
      m_scene = 0;
      m_err = 1'b0;
      elapsed = 0;
      return;
    end
    case (ph)
      P_IDLE: if (start) begin
        ph = P_LOAD;
        m_scene = 0;
        m_err = 1'b0;
      end
      P_LOAD: begin
        ph = P_HOLD;
        elapsed = 0;
      end
      P_HOLD: begin
        elapsed++;
        if (timer_done) ph = P_ADV;
        else if (pause) ph = P_PAUSE;
        else if (elapsed >= LIMIT) begin
          ph = P_ADV;
          m_err = 1'b1;
        end
      end
      P_PAUSE: if (!pause) ph = P_HOLD;
      P_ADV: begin
        if (m_scene < NS - 1) begin
          m_scene++;
          ph = P_LOAD;
        end else if (LOOP) begin
          m_scene = 0;
          ph = P_LOAD;
        end else ph = P_DONE;
      end
      P_DONE: ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("m_step", step, exp_step(ph));
    chk("m_scene", scene, 4'(m_scene));
    chk("m_busy", {3'b0, busy}, {3'b0, ph != P_IDLE});
    chk("m_err", {3'b0, timeout_err}, {3'b0, m_err});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic begin_seq();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_step(input string tag, input logic [3:0] want,
                           input int bound, output int n);
    n = 0;
    while (step !== want && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, step, want);
  endtask

  int n;

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_step", step, 4'b0000);
    chk("rst_scene", scene, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_err", {3'b0, timeout_err}, 4'd0);
    rst = 1'b1;

    // Full sequence driven by timer_done three clocks into each HOLD
    begin_seq();
    for (int s = 0; s < NS; s++) begin
      chk("a_load", step, 4'b0001);
      chk("a_scene", scene, 4'(s));
      repeat (3) begin
        cyc();
        chk("a_hold", step, 4'b0010);
      end
      timer_done = 1'b1;
      cyc();
      timer_done = 1'b0;
      chk("a_adv", step, 4'b0100);
      cyc();
    end
`ifdef SEQ_LOOP_EN
    chk("a_wrap_step", step, 4'b0001);
    chk("a_wrap_scene", scene, 4'd0);
    chk("a_wrap_busy", {3'b0, busy}, 4'd1);
`else
    chk("a_done", step, 4'b1000);
    cyc();
    chk("a_idle", step, 4'b0000);
    chk("a_idle_busy", {3'b0, busy}, 4'd0);
    chk("a_idle_scene", scene, 4'(NS - 1));
`endif

    // Timeout with no timer_done
    do_reset();
    begin_seq();
    cyc();
    chk("b_hold", step, 4'b0010);
    wait_step("b_adv", 4'b0100, 40, n);
    chk_int("b_latency", n, 20);
    chk("b_err", {3'b0, timeout_err}, 4'd1);
    cyc();
    cyc();
    chk("b_err_held", {3'b0, timeout_err}, 4'd1);
`ifndef SEQ_LOOP_EN
    for (int k = 0; k < 60 && busy; k++) begin
      timer_done = (ph == P_HOLD);
      cyc();
    end
    timer_done = 1'b0;
    chk("b_idle_err", {3'b0, timeout_err}, 4'd1);
    begin_seq();
    chk("b_clr_err", {3'b0, timeout_err}, 4'd0);
`endif

    // Pause freezes timing mid-HOLD
    do_reset();
    begin_seq();
    cyc();
    repeat (9) cyc();
    pause = 1'b1;
    repeat (7) begin
      cyc();
      chk("c_paused", step, 4'b0000);
    end
    pause = 1'b0;
    wait_step("c_adv", 4'b0100, 40, n);
    chk_int("c_resume_lat", n, 11);
    chk("c_err", {3'b0, timeout_err}, 4'd1);

    // timer_done beats pause; start ignored while busy
    do_reset();
    begin_seq();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("d_nostart", step, 4'b0010);
    timer_done = 1'b1;
    pause = 1'b1;
    cyc();
    timer_done = 1'b0;
    pause = 1'b0;
    chk("d_adv", step, 4'b0100);
    cyc();
    chk("d_scene1", scene, 4'd1);

    // Reset during PAUSED in scene 2
    do_reset();
    begin_seq();
    repeat (2) begin
      cyc();
      timer_done = 1'b1;
      cyc();
      timer_done = 1'b0;
      cyc();
    end
    cyc();
    chk("e_scene2", scene, 4'd2);
    pause = 1'b1;
    cyc();
    chk("e_paused", step, 4'b0000);
    chk("e_pbusy", {3'b0, busy}, 4'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("e_rstep", step, 4'b0000);
    chk("e_rscene", scene, 4'd0);
    chk("e_rbusy", {3'b0, busy}, 4'd0);
    pause = 1'b0;
    timer_done = 1'b1;
    cyc();
    timer_done = 1'b0;
    cyc();
    chk("e_ignored", step, 4'b0000);
    chk("e_ibusy", {3'b0, busy}, 4'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      timer_done = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
